// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the bit-serial ALU sequencer.
//   - WIDTH_DEFAULT : default operand/result width
//   - CTRL_*        : 4-bit alu_ctrl operation codes
//   - OP_*          : 2-bit slice operation select (AND / OR / SUM)
//   - state_t       : sequencer states IDLE / RUN / DONE
//   - slice_ctrl_t  : decoded slice controls plus per-op flags
//   - decode_ctrl / decode_b_invert : alu_ctrl decode helpers
package alu_ctrl_pkg;

  localparam int WIDTH_DEFAULT = 32;

  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
  localparam logic [3:0] CTRL_SLT = 4'b0111;
  localparam logic [3:0] CTRL_NOR = 4'b1100;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_SUM = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  typedef struct packed {
    logic       a_invert;
    logic       b_invert;
    logic [1:0] operation;
    logic       is_arith;  // ADD/SUB/SLT: overflow is meaningful
    logic       is_slt;    // result replaced by the sign-compare bit
    logic       legal;
  } slice_ctrl_t;

  function automatic slice_ctrl_t decode_ctrl(input logic [3:0] code);
    slice_ctrl_t d;
    d = '0;
    case (code)
      CTRL_AND: begin d.operation = OP_AND; d.legal = 1'b1; end
      CTRL_OR:  begin d.operation = OP_OR;  d.legal = 1'b1; end
      CTRL_ADD: begin d.operation = OP_SUM; d.is_arith = 1'b1; d.legal = 1'b1; end
      CTRL_SUB: begin
        d.b_invert = 1'b1; d.operation = OP_SUM; d.is_arith = 1'b1; d.legal = 1'b1;
      end
      CTRL_SLT: begin
        d.b_invert = 1'b1; d.operation = OP_SUM; d.is_arith = 1'b1;
        d.is_slt = 1'b1; d.legal = 1'b1;
      end
      CTRL_NOR: begin
        d.a_invert = 1'b1; d.b_invert = 1'b1; d.operation = OP_AND; d.legal = 1'b1;
      end
      default: d = '0;
    endcase
    return d;
  endfunction

  // b_invert alone seeds the carry flip-flop on accept (the +1 of two's complement).
  function automatic logic decode_b_invert(input logic [3:0] code);
    case (code)
      CTRL_SUB, CTRL_SLT, CTRL_NOR: return 1'b1;
      default:                      return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/bit_serial_alu_ctrl_if.sv
// Request/response bundle of the bit-serial ALU sequencer.
//   master : drives start, alu_ctrl, src_a, src_b; observes status and results
//   slave  : the sequencer side
interface bit_serial_alu_ctrl_if
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
);
  logic             start;
  logic [3:0]       alu_ctrl;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic             illegal;

  modport master (
    output start, alu_ctrl, src_a, src_b,
    input  ready, busy, done, result, zero, overflow, illegal
  );

  modport slave (
    input  start, alu_ctrl, src_a, src_b,
    output ready, busy, done, result, zero, overflow, illegal
  );
endinterface

// File: rtl/alu_bit_slice.sv
// Combinational one-bit ALU slice.
//   a, b        : operand bits
//   carry_in    : carry from the previous (less significant) bit
//   a_invert    : invert a before use
//   b_invert    : invert b before use
//   operation   : 00 AND, 01 OR, 10 full-adder sum, 11 drives 0
//   result      : selected slice output
//   carry_out   : full-adder carry (valid whatever operation selects)
module alu_bit_slice
  import alu_ctrl_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       carry_in,
  input  logic       a_invert,
  input  logic       b_invert,
  input  logic [1:0] operation,
  output logic       result,
  output logic       carry_out
);
  logic a_eff;
  logic b_eff;

  assign a_eff     = a ^ a_invert;
  assign b_eff     = b ^ b_invert;
  assign carry_out = (a_eff & b_eff) | (carry_in & (a_eff ^ b_eff));

  always_comb begin
    result = 1'b0;
    case (operation)
      OP_AND:  result = a_eff & b_eff;
      OP_OR:   result = a_eff | b_eff;
      OP_SUM:  result = a_eff ^ b_eff ^ carry_in;
      default: result = 1'b0;
    endcase
  end
endmodule

// File: rtl/bit_serial_alu_ctrl.sv
// Bit-serial ALU sequencer: runs a WIDTH-bit operation through a single
// one-bit slice, LSB first, one bit per clock.
//   clk   : clock, all state on rising edge
//   rst_n : synchronous active-low reset
//   bus   : slave side of bit_serial_alu_ctrl_if (start/ready/busy/done,
//           alu_ctrl, src_a, src_b, result, zero, overflow, illegal)
// An accepted request takes WIDTH RUN cycles, then one DONE cycle with done=1.
module bit_serial_alu_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
)
(
  input  logic                clk,
  input  logic                rst_n,
  bit_serial_alu_ctrl_if.slave bus
);
  localparam int             CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST_IDX = CW'(WIDTH - 1);

  state_t           state_reg, state_next;
  logic [CW-1:0]    idx_reg;
  logic             carry_reg;
  logic [3:0]       ctrl_reg;
  logic [WIDTH-1:0] opa_reg;
  logic [WIDTH-1:0] opb_reg;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shift_next;
  logic [WIDTH-1:0] result_reg;
  logic             zero_reg;
  logic             overflow_reg;
  logic             illegal_reg;

  slice_ctrl_t      run_dec;
  logic             slice_res;
  logic             slice_cout;
  logic             accept;
  logic             last_bit;
  logic             msb_ovf;
  logic             final_ovf;
  logic [WIDTH-1:0] final_result;

  // Decode from the latched code so input changes after accept are ignored.
  assign run_dec = decode_ctrl(ctrl_reg);

  alu_bit_slice u_slice (
    .a         (opa_reg[idx_reg]),
    .b         (opb_reg[idx_reg]),
    .carry_in  (carry_reg),
    .a_invert  (run_dec.a_invert),
    .b_invert  (run_dec.b_invert),
    .operation (run_dec.operation),
    .result    (slice_res),
    .carry_out (slice_cout)
  );

  // Slice output lands at bit idx; other bits keep their value.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
      assign shift_next[gi] = (idx_reg == CW'(gi)) ? slice_res : shift_reg[gi];
    end
  endgenerate

  // Only meaningful while the MSB is in the slice (last_bit).
  assign msb_ovf   = carry_reg ^ slice_cout;
  assign final_ovf = run_dec.is_arith & msb_ovf;

  always_comb begin
    final_result = shift_next;
    if (!run_dec.legal) begin
      final_result = '0;
    end else if (run_dec.is_slt) begin
      // Sign of (a-b) corrected by overflow gives the true signed compare.
      final_result = {{(WIDTH-1){1'b0}}, slice_res ^ msb_ovf};
    end
  end

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    last_bit   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (idx_reg == LAST_IDX) begin
          last_bit   = 1'b1;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      idx_reg      <= '0;
      carry_reg    <= 1'b0;
      ctrl_reg     <= '0;
      opa_reg      <= '0;
      opb_reg      <= '0;
      shift_reg    <= '0;
      result_reg   <= '0;
      zero_reg     <= 1'b0;
      overflow_reg <= 1'b0;
      illegal_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        ctrl_reg  <= bus.alu_ctrl;
        opa_reg   <= bus.src_a;
        opb_reg   <= bus.src_b;
        idx_reg   <= '0;
        carry_reg <= decode_b_invert(bus.alu_ctrl);
      end else if (state_reg == RUN) begin
        shift_reg <= shift_next;
        carry_reg <= slice_cout;
        idx_reg   <= idx_reg + 1'b1;
        if (last_bit) begin
          result_reg   <= final_result;
          zero_reg     <= (final_result == '0);
          overflow_reg <= final_ovf;
          illegal_reg  <= ~run_dec.legal;
        end
      end
    end
  end

  assign bus.ready    = (state_reg == IDLE);
  assign bus.busy     = (state_reg == RUN);
  assign bus.done     = (state_reg == DONE);
  assign bus.result   = result_reg;
  assign bus.zero     = zero_reg;
  assign bus.overflow = overflow_reg;
  assign bus.illegal  = illegal_reg;

endmodule

// File: tb/tb_bit_serial_alu_ctrl.sv
// Directed testbench for bit_serial_alu_ctrl at WIDTH=8.
module tb_bit_serial_alu_ctrl;
  import alu_ctrl_pkg::*;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  bit_serial_alu_ctrl_if #(.WIDTH(W)) bus ();

  bit_serial_alu_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Issue one request once ready, then wait (bounded) for done.
  // Returns with outputs sampled in the done cycle; lat = cycles accept->done or -1.
  task automatic do_op(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int lat);
    int guard;
    guard = 0;
    while (!bus.ready && guard < 40) begin
      @(posedge clk); #1; guard++;
    end
    bus.start = 1'b1; bus.alu_ctrl = c; bus.src_a = a; bus.src_b = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (bus.done) begin lat = i; break; end
    end
    $display("op ctrl=%b a=%h b=%h -> result=%h zero=%b ovf=%b illegal=%b latency=%0d",
             c, a, b, bus.result, bus.zero, bus.overflow, bus.illegal, lat);
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.alu_ctrl = '0; bus.src_a = '0; bus.src_b = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.ready, bus.busy, bus.done, bus.zero, bus.overflow, bus.illegal} !== 6'b100000) begin
      failures++;
      $display("FAIL reset_status: got rdy/busy/done/z/ovf/ill=%b expected 100000",
               {bus.ready, bus.busy, bus.done, bus.zero, bus.overflow, bus.illegal});
    end
    checks++;
    if (bus.result !== 8'h00) begin
      failures++; $display("FAIL reset_result: got %h expected 00", bus.result);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    int lat;
    do_op(CTRL_ADD, 8'h05, 8'h07, lat);
    checks++;
    if (lat !== 8) begin failures++; $display("FAIL add_latency: got %0d expected 8", lat); end
    checks++;
    if (bus.result !== 8'h0C) begin failures++; $display("FAIL add_result: got %h expected 0c", bus.result); end
    checks++;
    if ({bus.zero, bus.overflow, bus.illegal} !== 3'b000) begin
      failures++; $display("FAIL add_flags: got %b expected 000", {bus.zero, bus.overflow, bus.illegal});
    end
    @(posedge clk); #1;
    checks++;
    if ({bus.done, bus.ready, bus.result} !== {2'b01, 8'h0C}) begin
      failures++; $display("FAIL add_after_done: got done/ready/result=%b/%b/%h expected 0/1/0c",
                           bus.done, bus.ready, bus.result);
    end
  endtask

  task automatic test_add_sub_overflow();
    int lat;
    do_op(CTRL_ADD, 8'h7F, 8'h01, lat);
    checks++;
    if ({bus.result, bus.overflow, bus.zero} !== {8'h80, 2'b10}) begin
      failures++; $display("FAIL add_ovf: got result=%h ovf=%b zero=%b expected 80/1/0",
                           bus.result, bus.overflow, bus.zero);
    end
    do_op(CTRL_SUB, 8'h10, 8'h10, lat);
    checks++;
    if ({bus.result, bus.overflow, bus.zero} !== {8'h00, 2'b01}) begin
      failures++; $display("FAIL sub_zero: got result=%h ovf=%b zero=%b expected 00/0/1",
                           bus.result, bus.overflow, bus.zero);
    end
  endtask

  task automatic test_slt();
    int lat;
    do_op(CTRL_SLT, 8'hFD, 8'h02, lat);
    checks++;
    if ({bus.result, bus.overflow, bus.zero} !== {8'h01, 2'b00}) begin
      failures++; $display("FAIL slt_neg_pos: got result=%h ovf=%b zero=%b expected 01/0/0",
                           bus.result, bus.overflow, bus.zero);
    end
    do_op(CTRL_SLT, 8'h02, 8'hFD, lat);
    checks++;
    if ({bus.result, bus.overflow, bus.zero} !== {8'h00, 2'b01}) begin
      failures++; $display("FAIL slt_pos_neg: got result=%h ovf=%b zero=%b expected 00/0/1",
                           bus.result, bus.overflow, bus.zero);
    end
    do_op(CTRL_SLT, 8'h80, 8'h01, lat);
    checks++;
    if ({bus.result, bus.overflow, bus.zero} !== {8'h01, 2'b10}) begin
      failures++; $display("FAIL slt_ovf_path: got result=%h ovf=%b zero=%b expected 01/1/0",
                           bus.result, bus.overflow, bus.zero);
    end
  endtask

  task automatic test_logic();
    int lat;
    do_op(CTRL_NOR, 8'h0F, 8'hF0, lat);
    checks++;
    if ({bus.result, bus.overflow, bus.zero, bus.illegal} !== {8'h00, 3'b010}) begin
      failures++; $display("FAIL nor: got result=%h ovf=%b zero=%b ill=%b expected 00/0/1/0",
                           bus.result, bus.overflow, bus.zero, bus.illegal);
    end
    do_op(CTRL_AND, 8'hF0, 8'h3C, lat);
    checks++;
    if ({bus.result, bus.zero} !== {8'h30, 1'b0}) begin
      failures++; $display("FAIL and: got result=%h zero=%b expected 30/0", bus.result, bus.zero);
    end
    do_op(CTRL_OR, 8'hF0, 8'h0F, lat);
    checks++;
    if ({bus.result, bus.zero} !== {8'hFF, 1'b0}) begin
      failures++; $display("FAIL or: got result=%h zero=%b expected ff/0", bus.result, bus.zero);
    end
  endtask

  task automatic test_illegal();
    int lat;
    do_op(4'b0101, 8'h12, 8'h34, lat);
    checks++;
    if (lat !== 8) begin failures++; $display("FAIL illegal_latency: got %0d expected 8", lat); end
    checks++;
    if ({bus.result, bus.zero, bus.overflow, bus.illegal} !== {8'h00, 3'b101}) begin
      failures++; $display("FAIL illegal_out: got result=%h zero=%b ovf=%b ill=%b expected 00/1/0/1",
                           bus.result, bus.zero, bus.overflow, bus.illegal);
    end
  endtask

  task automatic test_back_to_back();
    int guard;
    int lat;
    guard = 0;
    while (!bus.ready && guard < 40) begin @(posedge clk); #1; guard++; end
    bus.start = 1'b1; bus.alu_ctrl = CTRL_ADD; bus.src_a = 8'h01; bus.src_b = 8'h02;
    @(posedge clk); #1;
    checks++;
    if ({bus.busy, bus.ready} !== 2'b10) begin
      failures++; $display("FAIL b2b_accept: got busy/ready=%b expected 10", {bus.busy, bus.ready});
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.src_a = 8'h10; bus.src_b = 8'h20;
    checks++;
    if ({bus.result, bus.illegal, bus.zero} !== {8'h00, 2'b11}) begin
      failures++; $display("FAIL b2b_hold_midrun: got result=%h ill=%b zero=%b expected 00/1/1",
                           bus.result, bus.illegal, bus.zero);
    end
    lat = -1;
    for (int i = 3; i <= 40; i++) begin
      @(posedge clk); #1;
      if (bus.done) begin lat = i; break; end
    end
    $display("op ctrl=%b a=01 b=02 (operands changed mid-run) -> result=%h latency=%0d",
             CTRL_ADD, bus.result, lat);
    checks++;
    if (lat !== 8) begin failures++; $display("FAIL b2b_latency: got %0d expected 8", lat); end
    checks++;
    if ({bus.result, bus.illegal} !== {8'h03, 1'b0}) begin
      failures++; $display("FAIL b2b_first_result: got result=%h ill=%b expected 03/0",
                           bus.result, bus.illegal);
    end
    @(posedge clk); #1;
    checks++;
    if ({bus.ready, bus.busy, bus.done} !== 3'b100) begin
      failures++; $display("FAIL b2b_no_queue: got ready/busy/done=%b expected 100",
                           {bus.ready, bus.busy, bus.done});
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    checks++;
    if ({bus.ready, bus.busy} !== 2'b01) begin
      failures++; $display("FAIL b2b_second_accept: got ready/busy=%b expected 01", {bus.ready, bus.busy});
    end
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (bus.done) begin lat = i; break; end
    end
    $display("op ctrl=%b a=10 b=20 (second op) -> result=%h latency=%0d", CTRL_ADD, bus.result, lat);
    checks++;
    if ({bus.result, lat == 8} !== {8'h30, 1'b1}) begin
      failures++; $display("FAIL b2b_second_result: got result=%h latency=%0d expected 30/8",
                           bus.result, lat);
    end
  endtask

  task automatic test_reset_mid_run();
    int guard;
    int lat;
    int done_seen;
    do_op(CTRL_ADD, 8'h7F, 8'h01, lat);
    guard = 0;
    while (!bus.ready && guard < 40) begin @(posedge clk); #1; guard++; end
    bus.start = 1'b1; bus.alu_ctrl = CTRL_ADD; bus.src_a = 8'h05; bus.src_b = 8'h07;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    $display("reset applied at RUN bit 3");
    checks++;
    if ({bus.ready, bus.busy, bus.done, bus.zero, bus.overflow, bus.illegal} !== 6'b100000) begin
      failures++;
      $display("FAIL midrun_reset_status: got rdy/busy/done/z/ovf/ill=%b expected 100000",
               {bus.ready, bus.busy, bus.done, bus.zero, bus.overflow, bus.illegal});
    end
    checks++;
    if (bus.result !== 8'h00) begin
      failures++; $display("FAIL midrun_reset_result: got %h expected 00", bus.result);
    end
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (bus.done) done_seen++;
    end
    checks++;
    if (done_seen !== 0) begin
      failures++; $display("FAIL midrun_reset_no_done: got %0d done pulses expected 0", done_seen);
    end
    do_op(CTRL_ADD, 8'h01, 8'h01, lat);
    checks++;
    if ({bus.result, lat == 8} !== {8'h02, 1'b1}) begin
      failures++; $display("FAIL post_reset_add: got result=%h latency=%0d expected 02/8",
                           bus.result, lat);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_add_sub_overflow();
    test_slt();
    test_logic();
    test_illegal();
    test_back_to_back();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
